// File: rtl/space_inv_pkg.sv
// ============================================================================
// space_inv_pkg: shared types and playfield constants for the invaders datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

package space_inv_pkg;

  typedef logic [10:0] coord_t;

  localparam int NUM_BOLTS  = 4;
  localparam int TOP_BORDER = 8;
  localparam int B_BORDER   = 400;

  typedef enum logic [0:0] {
    READY = 1'b0,
    COOL  = 1'b1
  } fire_state_e;

endpackage

`default_nettype wire

// File: rtl/bolt_slot_alloc.sv
// ============================================================================
// bolt_slot_alloc: lowest-free-index priority encoder over a slot live vector
// Revision: 1.0
// ============================================================================
`default_nettype none

module bolt_slot_alloc #(
  parameter int N = 4
) (
  input  logic [N-1:0]         exs_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!exs_i[i]) idx_o = ($clog2(N))'(i);
    end
    valid_o = ~&exs_i;
  end

endmodule

`default_nettype wire

// File: rtl/bolt_manager.sv
// ============================================================================
// bolt_manager: allocates, moves and retires player and invader bolt slots
// Revision: 1.0
// ============================================================================
`default_nettype none

module bolt_manager
  import space_inv_pkg::*;
#(
  parameter int PLR_STEP = 4,
  parameter int INV_STEP = 2,
  parameter int COOLDOWN = 16
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         enable,
  input  logic                         moveTick,
  input  logic                         fireReq,
  input  coord_t                       plrX,
  input  coord_t                       plrY,
  input  logic                         invFire,
  input  coord_t                       invX,
  input  coord_t                       invY,
  input  logic   [NUM_BOLTS-1:0]       btpHit,
  input  logic   [NUM_BOLTS-1:0]       btiHit,
  output logic   [NUM_BOLTS-1:0]       btpExs,
  output logic   [NUM_BOLTS-1:0]       btiExs,
  output coord_t [NUM_BOLTS-1:0]       btpX,
  output coord_t [NUM_BOLTS-1:0]       btpY,
  output coord_t [NUM_BOLTS-1:0]       btiX,
  output coord_t [NUM_BOLTS-1:0]       btiY,
  output logic                         fireAck,
  output logic                         invDrop
);

  localparam int IW = $clog2(NUM_BOLTS);
  localparam int CW = $clog2(COOLDOWN + 1);

  fire_state_e                 state_q;
  logic [CW-1:0]               cool_q;
  logic                        fire_prev_q;
  logic                        fire_ack_q, inv_drop_q;

  logic   [NUM_BOLTS-1:0]      btp_exs_q, btp_exs_d, bti_exs_q, bti_exs_d;
  coord_t [NUM_BOLTS-1:0]      btp_x_q, btp_x_d, btp_y_q, btp_y_d;
  coord_t [NUM_BOLTS-1:0]      bti_x_q, bti_x_d, bti_y_q, bti_y_d;

  logic [IW-1:0] plr_idx, inv_idx;
  logic          plr_free, inv_free;
  logic          fire_edge, plr_accept, inv_accept;

  bolt_slot_alloc #(.N(NUM_BOLTS)) u_plr_alloc (
    .exs_i   (btp_exs_q),
    .idx_o   (plr_idx),
    .valid_o (plr_free)
  );

  bolt_slot_alloc #(.N(NUM_BOLTS)) u_inv_alloc (
    .exs_i   (bti_exs_q),
    .idx_o   (inv_idx),
    .valid_o (inv_free)
  );

  assign fire_edge  = fireReq & ~fire_prev_q;
  assign plr_accept = enable & (state_q == READY) & fire_edge & plr_free;
  assign inv_accept = enable & invFire & inv_free;

  // Per-slot priority: flush, then hit on a live slot, then allocation, then movement.
  always_comb begin
    btp_exs_d = btp_exs_q;
    btp_x_d   = btp_x_q;
    btp_y_d   = btp_y_q;
    bti_exs_d = bti_exs_q;
    bti_x_d   = bti_x_q;
    bti_y_d   = bti_y_q;
    for (int i = 0; i < NUM_BOLTS; i++) begin
      if (!enable) begin
        btp_exs_d[i] = 1'b0;
        bti_exs_d[i] = 1'b0;
      end else begin
        if (btpHit[i] && btp_exs_q[i]) begin
          btp_exs_d[i] = 1'b0;
        end else if (plr_accept && (plr_idx == IW'(i))) begin
          btp_exs_d[i] = 1'b1;
          btp_x_d[i]   = plrX;
          btp_y_d[i]   = plrY;
        end else if (moveTick && btp_exs_q[i]) begin
          if (btp_y_q[i] < coord_t'(TOP_BORDER + PLR_STEP)) btp_exs_d[i] = 1'b0;
          else btp_y_d[i] = btp_y_q[i] - coord_t'(PLR_STEP);
        end

        if (btiHit[i] && bti_exs_q[i]) begin
          bti_exs_d[i] = 1'b0;
        end else if (inv_accept && (inv_idx == IW'(i))) begin
          bti_exs_d[i] = 1'b1;
          bti_x_d[i]   = invX;
          bti_y_d[i]   = invY;
        end else if (moveTick && bti_exs_q[i]) begin
          if (({1'b0, bti_y_q[i]} + 12'(INV_STEP)) > 12'(B_BORDER)) bti_exs_d[i] = 1'b0;
          else bti_y_d[i] = bti_y_q[i] + coord_t'(INV_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= READY;
      cool_q      <= '0;
      fire_prev_q <= 1'b0;
      fire_ack_q  <= 1'b0;
      inv_drop_q  <= 1'b0;
      btp_exs_q   <= '0;
      btp_x_q     <= '0;
      btp_y_q     <= '0;
      bti_exs_q   <= '0;
      bti_x_q     <= '0;
      bti_y_q     <= '0;
    end else begin
      fire_prev_q <= fireReq;
      fire_ack_q  <= plr_accept;
      inv_drop_q  <= enable & invFire & ~inv_free;
      btp_exs_q   <= btp_exs_d;
      btp_x_q     <= btp_x_d;
      btp_y_q     <= btp_y_d;
      bti_exs_q   <= bti_exs_d;
      bti_x_q     <= bti_x_d;
      bti_y_q     <= bti_y_d;
      if (!enable) begin
        state_q <= READY;
        cool_q  <= '0;
      end else begin
        case (state_q)
          READY: begin
            if (plr_accept) begin
              state_q <= COOL;
              cool_q  <= CW'(COOLDOWN);
            end
          end
          COOL: begin
            if (moveTick) begin
              cool_q <= cool_q - CW'(1);
              if (cool_q <= CW'(1)) state_q <= READY;
            end
          end
          default: state_q <= READY;
        endcase
      end
    end
  end

  assign btpExs  = btp_exs_q;
  assign btiExs  = bti_exs_q;
  assign btpX    = btp_x_q;
  assign btpY    = btp_y_q;
  assign btiX    = bti_x_q;
  assign btiY    = bti_y_q;
  assign fireAck = fire_ack_q;
  assign invDrop = inv_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_bolt_manager.sv
// ============================================================================
// tb_bolt_manager: directed plus randomized bench with a behavioural bolt model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bolt_manager;
  import space_inv_pkg::*;

  localparam int NB = NUM_BOLTS;
  localparam int PS = 4;
  localparam int IS = 2;
  localparam int CD = 16;

  logic clk = 1'b0;
  logic resetN = 1'b0, enable = 1'b0, moveTick = 1'b0, fireReq = 1'b0, invFire = 1'b0;
  coord_t plrX = '0, plrY = '0, invX = '0, invY = '0;
  logic [NB-1:0] btpHit = '0, btiHit = '0;

  logic   [NB-1:0] btpExs, btiExs;
  coord_t [NB-1:0] btpX, btpY, btiX, btiY;
  logic            fireAck, invDrop;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit     m_pl[NB], m_il[NB];
  coord_t m_px[NB], m_py[NB], m_ix[NB], m_iy[NB];
  int     m_cool;
  bit     m_ready, m_prev, m_ack, m_drop;

  bolt_manager #(.PLR_STEP(PS), .INV_STEP(IS), .COOLDOWN(CD)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .moveTick(moveTick),
    .fireReq(fireReq), .plrX(plrX), .plrY(plrY),
    .invFire(invFire), .invX(invX), .invY(invY),
    .btpHit(btpHit), .btiHit(btiHit),
    .btpExs(btpExs), .btiExs(btiExs),
    .btpX(btpX), .btpY(btpY), .btiX(btiX), .btiY(btiY),
    .fireAck(fireAck), .invDrop(invDrop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_pl[i] = 0; m_il[i] = 0;
      m_px[i] = '0; m_py[i] = '0; m_ix[i] = '0; m_iy[i] = '0;
    end
    m_cool = 0; m_ready = 1; m_prev = 0; m_ack = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int  fp, fi;
    bit  edge_seen;
    if (!resetN) begin
      model_reset();
      return;
    end
    fp = -1;
    fi = -1;
    for (int i = 0; i < NB; i++) if (!m_pl[i]) begin fp = i; break; end
    for (int i = 0; i < NB; i++) if (!m_il[i]) begin fi = i; break; end
    edge_seen = fireReq && !m_prev;
    m_prev = fireReq;
    if (!enable) begin
      for (int i = 0; i < NB; i++) begin m_pl[i] = 0; m_il[i] = 0; end
      m_ready = 1; m_cool = 0; m_ack = 0; m_drop = 0;
      return;
    end
    m_ack  = m_ready && edge_seen && (fp >= 0);
    m_drop = invFire && (fi < 0);
    for (int i = 0; i < NB; i++) begin
      if (m_pl[i]) begin
        if (btpHit[i]) m_pl[i] = 0;
        else if (moveTick) begin
          if (int'(m_py[i]) - PS < TOP_BORDER) m_pl[i] = 0;
          else m_py[i] = coord_t'(int'(m_py[i]) - PS);
        end
      end
      if (m_il[i]) begin
        if (btiHit[i]) m_il[i] = 0;
        else if (moveTick) begin
          if (int'(m_iy[i]) + IS > B_BORDER) m_il[i] = 0;
          else m_iy[i] = coord_t'(int'(m_iy[i]) + IS);
        end
      end
    end
    if (m_ack) begin m_pl[fp] = 1; m_px[fp] = plrX; m_py[fp] = plrY; end
    if (invFire && fi >= 0) begin m_il[fi] = 1; m_ix[fi] = invX; m_iy[fi] = invY; end
    if (!m_ready && moveTick) begin
      m_cool--;
      if (m_cool == 0) m_ready = 1;
    end
    if (m_ack) begin m_ready = 0; m_cool = CD; end
  endtask

  task automatic compare_all();
    logic   [NB-1:0] e_pe, e_ie;
    coord_t [NB-1:0] e_px, e_py, e_ix, e_iy;
    for (int i = 0; i < NB; i++) begin
      e_pe[i] = m_pl[i]; e_ie[i] = m_il[i];
      e_px[i] = m_px[i]; e_py[i] = m_py[i];
      e_ix[i] = m_ix[i]; e_iy[i] = m_iy[i];
    end
    chk("btpExs", btpExs, e_pe);
    chk("btiExs", btiExs, e_ie);
    chk("btpX", btpX, e_px);
    chk("btpY", btpY, e_py);
    chk("btiX", btiX, e_ix);
    chk("btiY", btiY, e_iy);
    chk("fireAck", fireAck, m_ack);
    chk("invDrop", invDrop, m_drop);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic tick();
    moveTick = 1'b1;
    cyc();
    moveTick = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    chk("reset_btpExs", btpExs, 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    enable = 1'b1;
    cyc();

    // First shot and the held-key / cooldown behaviour
    plrX = 11'd320; plrY = 11'd380; fireReq = 1'b1;
    cyc();
    chk("plan_ack", fireAck, 1);
    chk("plan_exs", btpExs, 4'b0001);
    chk("plan_x0", btpX[0], 320);
    chk("plan_y0", btpY[0], 380);
    cyc();
    chk("plan_ack_once", fireAck, 0);
    tick(); chk("tick1_y", btpY[0], 376);
    tick(); chk("tick2_y", btpY[0], 372);
    tick(); chk("tick3_y", btpY[0], 368);
    chk("held_no_second", btpExs, 4'b0001);
    fireReq = 1'b0; cyc();
    fireReq = 1'b1; cyc();
    chk("cool_ignore", fireAck, 0);
    fireReq = 1'b0;
    repeat (12) tick();
    fireReq = 1'b1; cyc();
    chk("cool_tick15_ignore", fireAck, 0);
    fireReq = 1'b0;
    tick();
    fireReq = 1'b1; cyc();
    chk("after16_ack", fireAck, 1);
    chk("after16_exs", btpExs, 4'b0011);
    fireReq = 1'b0;

    // Top-border retirement
    repeat (16) tick();
    plrY = 11'd10; fireReq = 1'b1; cyc(); fireReq = 1'b0;
    chk("y10_alloc", btpExs, 4'b0111);
    tick();
    chk("y10_retired", btpExs[2], 0);
    repeat (16) tick();
    plrY = 11'd12; fireReq = 1'b1; cyc(); fireReq = 1'b0;
    chk("y12_alloc", btpExs[2], 1);
    tick();
    chk("y12_to8", btpY[2], 8);
    chk("y12_live", btpExs[2], 1);
    tick();
    chk("y8_retired", btpExs[2], 0);
    enable = 1'b0; cyc(); enable = 1'b1;
    chk("flush_plr", btpExs, 0);

    // Invader allocation, overflow drop, hit with concurrent fire
    invX = 11'd100;
    for (int k = 0; k < 5; k++) begin
      invY = coord_t'(200 + k); invFire = 1'b1; cyc();
      chk("inv_drop_k", invDrop, (k == 4) ? 1 : 0);
    end
    invFire = 1'b0;
    chk("inv_full", btiExs, 4'b1111);
    btiHit = 4'b0100; invFire = 1'b1; cyc();
    chk("hit_clear", btiExs, 4'b1011);
    chk("hit_drop", invDrop, 1);
    btiHit = '0; invY = 11'd398; cyc(); invFire = 1'b0;
    chk("reuse2", btiExs, 4'b1111);
    chk("reuse2_y", btiY[2], 398);
    tick(); chk("inv_y400", btiY[2], 400);
    chk("inv_y400_live", btiExs[2], 1);
    tick(); chk("inv_retired", btiExs[2], 0);

    // Flush with live bolts, key held across enable rising
    fireReq = 1'b1; cyc();
    chk("pre_flush_ack", fireAck, 1);
    enable = 1'b0; cyc();
    chk("flush_p", btpExs, 0);
    chk("flush_i", btiExs, 0);
    enable = 1'b1;
    repeat (3) begin
      cyc();
      chk("held_enable_noack", fireAck, 0);
    end
    fireReq = 1'b0;

    // Asynchronous reset mid-operation
    invFire = 1'b1; invY = 11'd50; repeat (2) cyc(); invFire = 1'b0;
    resetN = 1'b0;
    #2;
    model_reset();
    compare_all();
    chk("async_rst", btiExs, 0);
    @(negedge clk);
    resetN = 1'b1;
    cyc();

    // Randomized traffic
    repeat (3000) begin
      if ($urandom_range(7) == 0) fireReq = ~fireReq;
      moveTick = ($urandom_range(2) == 0);
      invFire  = ($urandom_range(4) == 0);
      enable   = ($urandom_range(59) != 0);
      for (int i = 0; i < NB; i++) begin
        btpHit[i] = ($urandom_range(9) == 0);
        btiHit[i] = ($urandom_range(9) == 0);
      end
      plrX = coord_t'($urandom_range(2047));
      plrY = coord_t'($urandom_range(500));
      invX = coord_t'($urandom_range(2047));
      invY = coord_t'($urandom_range(420));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
